// File: rtl/tx_scheduler_pkg.sv
// Monitor-protocol constants shared by the transmit scheduler and the opcode encoder:
// fixed packet words, packet source codes and scheduler state codes.
package tx_scheduler_pkg;

   localparam logic [39:0] PKT_POWER_ON  = 40'hC0_0000_0000;
   localparam logic [39:0] PKT_AUDIO_REQ = 40'hC7_0000_0000;

   localparam logic [1:0] SRC_NONE  = 2'd0;
   localparam logic [1:0] SRC_POWER = 2'd1;
   localparam logic [1:0] SRC_AUDIO = 2'd2;
   localparam logic [1:0] SRC_KBD   = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   function automatic logic [39:0] pkt_word(input logic [1:0] src, input logic [39:0] kbd_buf);
      logic [39:0] word;
      case (src)
         SRC_POWER: word = PKT_POWER_ON;
         SRC_AUDIO: word = PKT_AUDIO_REQ;
         SRC_KBD:   word = kbd_buf;
         default:   word = '0;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/tx_scheduler_frame_timer.sv
// Down-counting frame timer: loaded at packet start, flags the last cycle of the frame.
module tx_scheduler_frame_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             mon_clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge mon_clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expires on the cycle the count steps down to zero.
   assign done = en & (count_q <= WIDTH'(1));

endmodule

// File: rtl/tx_scheduler.sv
// Transmit scheduler: arbitrates power, audio and keyboard packets onto the monitor
// serial link, starting at most one packet per FRAME_CYCLES.
module tx_scheduler
   import tx_scheduler_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES = 48,
   parameter int unsigned KBD_MAX_SKIP = 2
) (
   input  logic        mon_clk,
   input  logic        reset,
   input  logic        power_on_req,
   input  logic        audio_req,
   input  logic        kbd_valid,
   input  logic [39:0] kbd_data,
   output logic        kbd_ready,
   output logic [39:0] out_data,
   output logic        out_valid,
   output logic [1:0]  out_src,
   output logic        busy
);

   localparam logic [7:0] LoadVal = 8'(FRAME_CYCLES - 2);
   localparam logic [7:0] SkipMax = 8'(KBD_MAX_SKIP);

   logic [1:0]  state_q, state_d;
   logic        pwr_pend_q, pwr_pend_d;
   logic        aud_pend_q, aud_pend_d;
   logic        kbd_full_q, kbd_full_d;
   logic [39:0] kbd_buf_q, kbd_buf_d;
   logic        audio_prev_q;
   logic [7:0]  skip_cnt_q, skip_cnt_d;
   logic [39:0] out_data_q;
   logic [1:0]  out_src_q;
   logic        is_load, kbd_xfer, timer_done;
   logic [1:0]  win_src;
   logic [39:0] win_data;

   assign is_load   = (state_q == ST_LOAD);
   assign kbd_ready = ~kbd_full_q & ~reset;
   assign kbd_xfer  = kbd_valid & kbd_ready;

   // Keyboard jumps ahead of audio once it has lost KBD_MAX_SKIP frames; power always wins.
   always_comb begin
      win_src = SRC_NONE;
      if (pwr_pend_q) begin
         win_src = SRC_POWER;
      end else if (kbd_full_q && ((skip_cnt_q >= SkipMax) || !aud_pend_q)) begin
         win_src = SRC_KBD;
      end else if (aud_pend_q) begin
         win_src = SRC_AUDIO;
      end
   end

   assign win_data = pkt_word(win_src, kbd_buf_q);

   always_comb begin
      pwr_pend_d = power_on_req | (pwr_pend_q & ~(is_load & (win_src == SRC_POWER)));
      aud_pend_d = (audio_req & ~audio_prev_q) | (aud_pend_q & ~(is_load & (win_src == SRC_AUDIO)));
      kbd_full_d = kbd_xfer | (kbd_full_q & ~(is_load & (win_src == SRC_KBD)));
      kbd_buf_d  = kbd_xfer ? kbd_data : kbd_buf_q;

      skip_cnt_d = skip_cnt_q;
      if (!kbd_full_q || (is_load && (win_src == SRC_KBD))) begin
         skip_cnt_d = '0;
      end else if (is_load && (skip_cnt_q < SkipMax)) begin
         skip_cnt_d = skip_cnt_q + 8'd1;
      end

      state_d = state_q;
      unique case (state_q)
         // Requests arriving this cycle count, so a fresh request issues next cycle.
         ST_IDLE: if (pwr_pend_d || aud_pend_d || kbd_full_d) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_WAIT;
         ST_WAIT: if (timer_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge mon_clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pwr_pend_q   <= 1'b0;
         aud_pend_q   <= 1'b0;
         kbd_full_q   <= 1'b0;
         kbd_buf_q    <= '0;
         audio_prev_q <= 1'b0;
         skip_cnt_q   <= '0;
         out_data_q   <= '0;
         out_src_q    <= SRC_NONE;
      end else begin
         state_q      <= state_d;
         pwr_pend_q   <= pwr_pend_d;
         aud_pend_q   <= aud_pend_d;
         kbd_full_q   <= kbd_full_d;
         kbd_buf_q    <= kbd_buf_d;
         audio_prev_q <= audio_req;
         skip_cnt_q   <= skip_cnt_d;
         if (is_load) begin
            out_data_q <= win_data;
            out_src_q  <= win_src;
         end
      end
   end

   assign out_valid = is_load;
   assign busy      = (state_q != ST_IDLE);
   assign out_data  = is_load ? win_data : out_data_q;
   assign out_src   = is_load ? win_src : out_src_q;

   tx_scheduler_frame_timer #(
      .WIDTH (8)
   ) u_frame_timer (
      .mon_clk  (mon_clk),
      .reset    (reset),
      .load     (is_load),
      .load_val (LoadVal),
      .en       (state_q == ST_WAIT),
      .done     (timer_done)
   );

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: frame/timestamp reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_tx_scheduler;

   localparam int unsigned FC  = 48;
   localparam int unsigned KMS = 2;
   localparam logic [39:0] PWR_WORD = 40'hC0_0000_0000;
   localparam logic [39:0] AUD_WORD = 40'hC7_0000_0000;

   logic        mon_clk = 1'b0;
   logic        reset = 1'b1;
   logic        power_on_req = 1'b0;
   logic        audio_req = 1'b0;
   logic        kbd_valid = 1'b0;
   logic [39:0] kbd_data = '0;
   logic        kbd_ready;
   logic [39:0] out_data;
   logic        out_valid;
   logic [1:0]  out_src;
   logic        busy;

   int checks = 0;
   int failures = 0;

   tx_scheduler #(
      .FRAME_CYCLES (FC),
      .KBD_MAX_SKIP (KMS)
   ) dut (
      .mon_clk      (mon_clk),
      .reset        (reset),
      .power_on_req (power_on_req),
      .audio_req    (audio_req),
      .kbd_valid    (kbd_valid),
      .kbd_data     (kbd_data),
      .kbd_ready    (kbd_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_src      (out_src),
      .busy         (busy)
   );

   always #5 mon_clk = ~mon_clk;

   longint cyc = 0;
   always @(posedge mon_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: pending set, time of last packet start, keyboard loss count.
   bit          m_on = 0;
   bit          m_pwr, m_aud, m_kbd, m_prev, m_issue;
   logic [39:0] m_word, m_data;
   logic [1:0]  m_src;
   int          m_skip;
   longint      m_last;

   always @(negedge mon_clk) begin
      bit kbd_was, ready_now, e_busy;
      if (m_on) begin
         kbd_was   = m_kbd;
         ready_now = !m_kbd;
         if (m_issue) begin
            if (m_pwr) begin
               m_src = 2'd1; m_data = PWR_WORD; m_pwr = 0;
            end else if (m_kbd && (m_skip >= int'(KMS) || !m_aud)) begin
               m_src = 2'd3; m_data = m_word; m_kbd = 0;
            end else begin
               m_src = 2'd2; m_data = AUD_WORD; m_aud = 0;
            end
            if (m_src == 2'd3) m_skip = 0;
            else if (kbd_was && m_skip < 255) m_skip++;
            m_last = cyc;
         end
         e_busy = (cyc - m_last) <= longint'(FC - 2);
         chk("model_valid", out_valid, m_issue);
         chk("model_data", out_data, m_data);
         chk("model_src", out_src, m_src);
         chk("model_busy", busy, e_busy);
         chk("model_ready", kbd_ready, ready_now && !reset);
         if (!reset) begin
            if (!kbd_was) m_skip = 0;
            if (power_on_req) m_pwr = 1;
            if (audio_req && !m_prev) m_aud = 1;
            m_prev = audio_req;
            if (kbd_valid && ready_now) begin
               m_kbd = 1; m_word = kbd_data;
            end
            m_issue = !e_busy && (m_pwr || m_aud || m_kbd);
         end
      end
      if (reset) begin
         m_on = 1; m_pwr = 0; m_aud = 0; m_kbd = 0; m_prev = 0; m_issue = 0;
         m_word = '0; m_data = '0; m_src = 2'd0; m_skip = 0; m_last = -1000;
      end
   end

   task automatic adv(input int n);
      repeat (n) begin
         @(posedge mon_clk);
         #1;
      end
   endtask

   task automatic smp();
      @(negedge mon_clk);
   endtask

   task automatic quiet(input int n);
      power_on_req = 0; audio_req = 0; kbd_valid = 0;
      adv(n);
   endtask

   task automatic count_pulses(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         adv(1);
         smp();
         if (out_valid) pulses++;
      end
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      // Reset state.
      adv(3);
      smp();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_src", out_src, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", kbd_ready, 0);
      adv(1); reset = 0;
      quiet(5);

      // Single audio edge: packet next cycle, frame ends 48 cycles after it.
      adv(1); audio_req = 1;
      adv(1); smp();
      chk("a_valid", out_valid, 1);
      chk("a_data", out_data, AUD_WORD);
      chk("a_src", out_src, 2);
      adv(1); audio_req = 0;
      adv(45); smp();
      chk("a_busy_end", busy, 1);
      adv(2); smp();
      chk("a_idle", busy, 0);
      chk("a_held", out_data, AUD_WORD);
      quiet(100);

      // Power and audio together: power first, audio one frame later.
      adv(1); power_on_req = 1; audio_req = 1;
      adv(1); power_on_req = 0; smp();
      chk("b_pwr_src", out_src, 1);
      chk("b_pwr_data", out_data, PWR_WORD);
      adv(1); audio_req = 0;
      adv(46); smp();
      chk("b_gap", out_valid, 0);
      adv(1); smp();
      chk("b_aud_valid", out_valid, 1);
      chk("b_aud_src", out_src, 2);
      quiet(150);

      // Keyboard starved by audio twice, then forced.
      adv(1); audio_req = 1; kbd_valid = 1; kbd_data = 40'h12_3456_789A;
      adv(1); kbd_valid = 0; smp();
      chk("c_first_src", out_src, 2);
      chk("c_ready_low", kbd_ready, 0);
      adv(1); audio_req = 0;
      adv(8); audio_req = 1;
      adv(1); audio_req = 0;
      adv(38); smp();
      chk("c_second_src", out_src, 2);
      adv(10); audio_req = 1;
      adv(1); audio_req = 0;
      adv(37); smp();
      chk("c_forced_src", out_src, 3);
      chk("c_forced_data", out_data, 40'h12_3456_789A);
      adv(1); smp();
      chk("c_ready_back", kbd_ready, 1);
      adv(47); smp();
      chk("c_aud_after", out_src, 2);
      quiet(150);

      // Three audio edges inside one frame merge into one packet.
      adv(1); audio_req = 1;
      adv(1); audio_req = 0;
      for (int k = 0; k < 3; k++) begin
         adv(4); audio_req = 1;
         adv(1); audio_req = 0;
      end
      adv(33); smp();
      chk("d_merged", out_valid, 1);
      count_pulses(100, pulses);
      chk("d_no_extra", pulses, 0);
      quiet(20);

      // kbd_valid held across two words: second accepted only after the grant.
      adv(1); kbd_valid = 1; kbd_data = 40'hAA_0000_0001; smp();
      chk("e_ready0", kbd_ready, 1);
      adv(1); kbd_data = 40'h55_0000_0002; smp();
      chk("e_ready1", kbd_ready, 0);
      chk("e_w1", out_data, 40'hAA_0000_0001);
      adv(1); smp();
      chk("e_ready2", kbd_ready, 1);
      adv(1); kbd_valid = 0;
      adv(46); smp();
      chk("e_w2", out_data, 40'h55_0000_0002);
      chk("e_w2_src", out_src, 3);
      quiet(150);

      // Reset mid-frame with audio pending aborts everything.
      adv(1); audio_req = 1;
      adv(1); audio_req = 0;
      adv(4); audio_req = 1;
      adv(1); audio_req = 0;
      adv(14); reset = 1;
      adv(1); smp();
      chk("f_valid", out_valid, 0);
      chk("f_data", out_data, 0);
      chk("f_src", out_src, 0);
      chk("f_busy", busy, 0);
      chk("f_ready", kbd_ready, 0);
      adv(1); reset = 0;
      count_pulses(80, pulses);
      chk("f_silent", pulses, 0);

      // audio_req already high when reset releases counts as an edge.
      adv(1); reset = 1; audio_req = 1;
      adv(2); reset = 0;
      adv(1); smp();
      chk("g_post_rst_valid", out_valid, 1);
      chk("g_post_rst_src", out_src, 2);
      quiet(100);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         adv(1);
         power_on_req = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 7) == 0) audio_req = ~audio_req;
         if (kbd_valid) begin
            if ($urandom_range(0, 3) == 0) kbd_valid = 0;
         end else if ($urandom_range(0, 15) == 0) begin
            kbd_valid = 1;
            kbd_data = {8'($urandom), 32'($urandom)};
         end
         reset = ($urandom_range(0, 999) == 0);
      end
      reset = 0;
      quiet(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
